// File: rtl/mem_ctrl.sv
// Byte-serial controller for a shared single-port 8-bit RAM: arbitrates IF fetches
// against MEM loads/stores (MEM wins) and moves one byte per cycle, little-endian.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              busy_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              own_mem_q, own_mem_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [1:0]        rd_idx;

  // Read data lags the address by one cycle, so the byte arriving at count c is byte c-1.
  assign rd_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    own_mem_d  = own_mem_q;
    we_d       = we_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    inst_d     = inst_q;
    rdata_d    = rdata_q;
    if_done_d  = if_done_q;
    mem_done_d = mem_done_q;
    if (rdy_in) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // A requester still seeing its done pulse is holding a stale request.
          if (mem_req_i && !mem_done_q) begin
            state_d   = BUSY;
            cnt_d     = 3'd0;
            own_mem_d = 1'b1;
            we_d      = mem_we_i;
            base_d    = mem_addr_i;
            n_d       = mem_len_i[1] ? 3'd4 : (mem_len_i[0] ? 3'd2 : 3'd1);
            wdata_d   = mem_wdata_i;
            rdata_d   = 32'd0;
          end else if (if_req_i && !if_done_q) begin
            state_d   = BUSY;
            cnt_d     = 3'd0;
            own_mem_d = 1'b0;
            we_d      = 1'b0;
            base_d    = if_addr_i;
            n_d       = 3'd4;
            wdata_d   = 32'd0;
            inst_d    = 32'd0;
          end
        end
        BUSY: begin
          if (we_q) begin
            if (cnt_q == n_q - 3'd1) begin
              state_d    = IDLE;
              mem_done_d = own_mem_q;
              if_done_d  = !own_mem_q;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            if (cnt_q != 3'd0) begin
              if (own_mem_q) rdata_d[{rd_idx, 3'b000} +: 8] = ram_din_i;
              else           inst_d[{rd_idx, 3'b000} +: 8]  = ram_din_i;
            end
            if (cnt_q == n_q) begin
              state_d    = IDLE;
              mem_done_d = own_mem_q;
              if_done_d  = !own_mem_q;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ram_a_o    = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'd0;
    if (state_q == BUSY) begin
      if (we_q || cnt_q != n_q) ram_a_o = base_q + ADDR_W'(cnt_q);
      if (we_q) begin
        ram_wr_o   = rdy_in;
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      own_mem_q  <= 1'b0;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= 32'd0;
      inst_q     <= 32'd0;
      rdata_q    <= 32'd0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      own_mem_q  <= own_mem_d;
      we_q       <= we_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      inst_q     <= inst_d;
      rdata_q    <= rdata_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_inst_o   = inst_q;
  assign mem_rdata_o = rdata_q;
  assign busy_o      = (state_q == BUSY);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a rdy-gated synchronous RAM, a byte-array reference model,
// directed scenarios and randomized transactions with random stalls.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [1:0]  mem_len_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i = '0;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i),
    .busy_o(busy_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // The RAM shares the pipeline's advance signal, so its read port freezes with rdy_in.
  always @(posedge clk) begin
    if (rdy_in) begin
      if (ram_wr_o) ram_mem[ram_a_o] = ram_dout_o;
      ram_din_i <= ram_rd(ram_a_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + i);
    return w;
  endfunction

  function automatic int len_bytes(input logic [1:0] len);
    return len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4);
  endfunction

  // One transaction judged by logical cycle index L: L counts grant-relative cycles,
  // advancing only across edges where rdy_in was high.
  task automatic do_txn(input bit is_mem, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall_at, input int stall_len);
    int n, l_done, l, k;
    logic [31:0] exp_data, exp_a;
    logic [7:0] exp_dout;
    bit exp_wr;
    n = is_mem ? len_bytes(len) : 4;
    l_done = we ? n + 1 : n + 2;
    exp_data = we ? 32'd0 : ref_word(addr, n);
    if (we) for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];

    @(negedge clk);
    rdy_in = 1'b1;
    if (is_mem) begin
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    l = 1;
    k = 1;
    while (l <= l_done && k < 60) begin
      @(negedge clk);
      rdy_in = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
      #1;
      exp_a    = (l <= n) ? addr + 32'(l - 1) : 32'd0;
      exp_wr   = we && (l <= n) && rdy_in;
      exp_dout = (we && l <= n) ? wdata[8*(l-1) +: 8] : 8'd0;
      check("ram_a", ram_a_o, exp_a);
      check("ram_wr", 32'(ram_wr_o), 32'(exp_wr));
      check("ram_dout", 32'(ram_dout_o), 32'(exp_dout));
      check("busy", 32'(busy_o), 32'(l < l_done));
      check(is_mem ? "mem_done" : "if_done", 32'(is_mem ? mem_done_o : if_done_o), 32'(l == l_done));
      check(is_mem ? "if_done_idle" : "mem_done_idle", 32'(is_mem ? if_done_o : mem_done_o), 32'd0);
      if (l == l_done) begin
        if (is_mem && !we) check("mem_rdata", mem_rdata_o, exp_data);
        if (!is_mem) check("if_inst", if_inst_o, exp_data);
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
      end
      if (rdy_in) l++;
      k++;
    end
    check("txn_budget", 32'(l > l_done), 32'd1);
    mem_req_i = 1'b0;
    if_req_i  = 1'b0;
    rdy_in    = 1'b1;
    @(negedge clk);
    #1;
    check("done_one_shot", 32'({if_done_o, mem_done_o, busy_o}), 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] w;
    // Reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_outs", 32'({if_done_o, mem_done_o, ram_wr_o, busy_o}), 32'd0);
    check("rst_inst", if_inst_o, 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    check("rst_ram_a", ram_a_o, 32'd0);
    check("rst_dout", 32'(ram_dout_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // IF fetch of 13,12,11,10 at 0x100
    for (int i = 0; i < 4; i++) begin
      ram_mem[32'h100 + i] = 8'h13 - 8'(i);
      ref_mem[32'h100 + i] = 8'h13 - 8'(i);
    end
    do_txn(1'b0, 1'b0, 2'd0, 32'h100, 32'd0, 99, 0);
    check("fetch_word", if_inst_o, 32'h1011_1213);

    // Halfword store
    do_txn(1'b1, 1'b1, 2'd1, 32'h20, 32'hAABB_CCDD, 99, 0);
    check("store_b0", 32'(ram_rd(32'h20)), 32'hDD);
    check("store_b1", 32'(ram_rd(32'h21)), 32'hCC);
    check("store_b2_untouched", 32'(ram_rd(32'h22)), 32'(init_byte(32'h22)));

    // Simultaneous requests: MEM byte load wins, IF follows right after mem_done_o
    ram_mem[32'h5] = 8'h80;
    ref_mem[32'h5] = 8'h80;
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h300;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'd0; mem_addr_i = 32'h5;
    @(negedge clk); #1;
    check("tie_mem_addr", ram_a_o, 32'h5);
    @(negedge clk); #1;
    check("tie_mem_done_early", 32'(mem_done_o), 32'd0);
    @(negedge clk); #1;
    check("tie_mem_done", 32'(mem_done_o), 32'd1);
    check("tie_mem_rdata", mem_rdata_o, 32'h0000_0080);
    check("tie_if_wait", 32'(if_done_o), 32'd0);
    mem_req_i = 1'b0;
    @(negedge clk); #1;
    check("tie_if_addr", ram_a_o, 32'h300);
    check("tie_if_busy", 32'(busy_o), 32'd1);
    k = 4;
    while (!if_done_o && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    check("tie_if_done_cycle", 32'(k), 32'd9);
    check("tie_if_inst", if_inst_o, ref_word(32'h300, 4));
    if_req_i = 1'b0;
    @(negedge clk);

    // IF fetch with a 3-cycle stall
    do_txn(1'b0, 1'b0, 2'd0, 32'h200, 32'd0, 2, 3);

    // Word load across the address wrap
    do_txn(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, 99, 0);

    // Reset while a word store is on its second byte
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'd2; mem_addr_i = 32'h40;
    mem_wdata_i = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk); #1;
    check("pre_rst_wr", 32'(ram_wr_o), 32'd1);
    check("pre_rst_a", ram_a_o, 32'h41);
    rst = 1'b0;
    mem_req_i = 1'b0;
    #1;
    check("rst_abort_outs", 32'({if_done_o, mem_done_o, ram_wr_o, busy_o}), 32'd0);
    check("rst_abort_a", ram_a_o, 32'd0);
    check("rst_abort_dout", 32'(ram_dout_o), 32'd0);
    ref_mem[32'h40] = 8'h44;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      check("post_rst_idle", 32'({mem_done_o, busy_o}), 32'd0);
    end
    do_txn(1'b1, 1'b0, 2'd2, 32'h40, 32'd0, 99, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit is_mem, we;
      logic [1:0] len;
      logic [31:0] addr;
      is_mem = 1'($urandom_range(0, 1));
      we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      len    = 2'($urandom_range(0, 3));
      addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                           : 32'h1000 + $urandom_range(0, 63);
      w      = $urandom;
      do_txn(is_mem, we, len, addr, w, $urandom_range(1, 7), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
